// File: rtl/reg_writeback_pkg.sv
// Shared types and default sizing for the register write-back block.
// reg_id_t : architectural register index (32 registers, r0 hard-wired zero)
// op_t     : operand / result word
// wb_entry_t : one buffered long-latency result (destination + data)
package reg_writeback_pkg;

  localparam int unsigned REG_ID_W = 5;
  localparam int unsigned OP_W     = 32;
  localparam int unsigned NUM_REGS = 32;

  localparam int unsigned WB_FIFO_DEPTH_DEFAULT      = 2;
  localparam int unsigned WB_MAX_OUTSTANDING_DEFAULT = 4;

  typedef logic [REG_ID_W-1:0] reg_id_t;
  typedef logic [OP_W-1:0]     op_t;

  typedef struct packed {
    reg_id_t id;
    op_t     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer holding LSU results until the write port is free.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   push_valid        : enqueue push_entry (accepted when not full, or when
//                       a pop happens in the same cycle)
//   push_entry        : result to enqueue
//   pop               : dequeue strobe (ignored when empty)
//   head              : oldest entry, valid while !empty
//   full, empty       : occupancy flags
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = WB_FIFO_DEPTH_DEFAULT
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_valid,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pointer increment with wrap at DEPTH (DEPTH need not be a power of two)
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push_valid && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; entries are only read once written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-back arbiter with long-latency destination scoreboard.
// ALU results write one cycle later and always win the write port; LSU
// results are buffered in wb_fifo and drain when the ALU is idle. A pending
// bit per register tracks reserved long-latency destinations for decode.
// Optional macro WB_BYPASS_EN adds forwarding outputs and clears pending
// bits one cycle earlier (on the edge that registers the LSU write).
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   alu_valid/alu_id/alu_data       : single-cycle result, always accepted
//   issue_valid/issue_id/issue_ready: reserve a long-latency destination
//   lsu_valid/lsu_id/lsu_data/lsu_ready : long-latency result handshake
//   enable_write/write_id/write_data: registered register-file write port
//   rs_id/rt_id, rs_pending/rt_pending : combinational hazard query
//   rs_fwd/rt_fwd, rs_fwd_data/rt_fwd_data : forwarding (WB_BYPASS_EN only)
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int unsigned WB_FIFO_DEPTH      = WB_FIFO_DEPTH_DEFAULT,
  parameter int unsigned WB_MAX_OUTSTANDING = WB_MAX_OUTSTANDING_DEFAULT
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    alu_valid,
  input  reg_id_t alu_id,
  input  op_t     alu_data,
  input  logic    issue_valid,
  input  reg_id_t issue_id,
  output logic    issue_ready,
  input  logic    lsu_valid,
  input  reg_id_t lsu_id,
  input  op_t     lsu_data,
  output logic    lsu_ready,
  output logic    enable_write,
  output reg_id_t write_id,
  output op_t     write_data,
`ifdef WB_BYPASS_EN
  output logic    rs_fwd,
  output logic    rt_fwd,
  output op_t     rs_fwd_data,
  output op_t     rt_fwd_data,
`endif
  input  reg_id_t rs_id,
  input  reg_id_t rt_id,
  output logic    rs_pending,
  output logic    rt_pending
);

  localparam int unsigned CNT_W = $clog2(WB_MAX_OUTSTANDING + 1);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_d;
  logic [CNT_W-1:0]    outstanding;
  wb_entry_t           fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic                alu_take;
  logic                issue_fire;
  logic                clr_fire;
  reg_id_t             clr_id;
  logic                wb_en_d;
  reg_id_t             wb_id_d;
  op_t                 wb_data_d;

  // Results for r0 are dropped outright: no write, no buffering
  assign lsu_ready = !fifo_full;
  assign fifo_push = lsu_valid && lsu_ready && (lsu_id != '0);
  assign alu_take  = alu_valid && (alu_id != '0);
  assign fifo_pop  = !alu_take && !fifo_empty;

  wb_fifo #(
    .DEPTH (WB_FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (fifo_push),
    .push_entry ({lsu_id, lsu_data}),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Write-port select: ALU first, then oldest buffered LSU result
  always_comb begin
    wb_en_d   = 1'b0;
    wb_id_d   = '0;
    wb_data_d = '0;
    if (alu_take) begin
      wb_en_d   = 1'b1;
      wb_id_d   = alu_id;
      wb_data_d = alu_data;
    end else if (fifo_pop) begin
      wb_en_d   = 1'b1;
      wb_id_d   = fifo_head.id;
      wb_data_d = fifo_head.data;
    end
  end

  // Registered write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable_write <= 1'b0;
      write_id     <= '0;
      write_data   <= '0;
    end else begin
      enable_write <= wb_en_d;
      write_id     <= wb_id_d;
      write_data   <= wb_data_d;
    end
  end

`ifdef WB_BYPASS_EN
  // Decode can forward the registered write, so the reservation ends as soon
  // as the write is registered
  assign clr_id   = fifo_head.id;
  assign clr_fire = fifo_pop && pending[fifo_head.id];

  assign rs_fwd      = enable_write && (write_id == rs_id) && (rs_id != '0);
  assign rt_fwd      = enable_write && (write_id == rt_id) && (rt_id != '0);
  assign rs_fwd_data = write_data;
  assign rt_fwd_data = write_data;
`else
  // Remembers that the current write came from the LSU path
  logic wb_from_lsu;

  always_ff @(posedge clk) begin
    if (!rst_n) wb_from_lsu <= 1'b0;
    else        wb_from_lsu <= fifo_pop;
  end

  // Without forwarding the reservation holds until the write is in the file
  assign clr_id   = write_id;
  assign clr_fire = enable_write && wb_from_lsu && pending[write_id];
`endif

  assign issue_ready = !pending[issue_id] && (outstanding < CNT_W'(WB_MAX_OUTSTANDING));
  assign issue_fire  = issue_valid && issue_ready && (issue_id != '0);

  // Clear applied before set so a same-bit collision leaves the bit set
  always_comb begin
    pending_d = pending;
    if (clr_fire)   pending_d[clr_id]   = 1'b0;
    if (issue_fire) pending_d[issue_id] = 1'b1;
  end

  // Scoreboard state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending     <= '0;
      outstanding <= '0;
    end else begin
      pending     <= pending_d;
      outstanding <= outstanding + CNT_W'(issue_fire) - CNT_W'(clr_fire);
    end
  end

  assign rs_pending = pending[rs_id] && (rs_id != '0);
  assign rt_pending = pending[rt_id] && (rt_id != '0);

  // An ALU write into a reserved register is a protocol violation upstream
  always_ff @(posedge clk) begin
    if (rst_n && alu_valid && (alu_id != '0)) begin
      assert (!pending[alu_id]);
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;
  import reg_writeback_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned MAXO  = 4;

  logic    clk;
  logic    rst_n;
  logic    alu_valid;
  reg_id_t alu_id;
  op_t     alu_data;
  logic    issue_valid;
  reg_id_t issue_id;
  logic    issue_ready;
  logic    lsu_valid;
  reg_id_t lsu_id;
  op_t     lsu_data;
  logic    lsu_ready;
  logic    enable_write;
  reg_id_t write_id;
  op_t     write_data;
  reg_id_t rs_id;
  reg_id_t rt_id;
  logic    rs_pending;
  logic    rt_pending;
`ifdef WB_BYPASS_EN
  logic    rs_fwd;
  logic    rt_fwd;
  op_t     rs_fwd_data;
  op_t     rt_fwd_data;
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reg_writeback #(
    .WB_FIFO_DEPTH      (DEPTH),
    .WB_MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_id       (alu_id),
    .alu_data     (alu_data),
    .issue_valid  (issue_valid),
    .issue_id     (issue_id),
    .issue_ready  (issue_ready),
    .lsu_valid    (lsu_valid),
    .lsu_id       (lsu_id),
    .lsu_data     (lsu_data),
    .lsu_ready    (lsu_ready),
    .enable_write (enable_write),
    .write_id     (write_id),
    .write_data   (write_data),
`ifdef WB_BYPASS_EN
    .rs_fwd       (rs_fwd),
    .rt_fwd       (rt_fwd),
    .rs_fwd_data  (rs_fwd_data),
    .rt_fwd_data  (rt_fwd_data),
`endif
    .rs_id        (rs_id),
    .rt_id        (rt_id),
    .rs_pending   (rs_pending),
    .rt_pending   (rt_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: result queue, reservation set, expected write port
  typedef struct {
    logic [4:0]  id;
    logic [31:0] d;
  } ent_t;

  ent_t        fq[$];
  bit          pend [32];
  bit          m_we;
  bit          m_from_lsu;
  logic [4:0]  m_id;
  logic [31:0] m_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int reserved_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(pend[i]);
    return c;
  endfunction

  task automatic idle();
    alu_valid   = 1'b0;
    issue_valid = 1'b0;
    lsu_valid   = 1'b0;
  endtask

  // One clock cycle: check combinational outputs, advance model, check write port
  task automatic step();
    ent_t pe;
    bit   exp_ir, exp_lr, have_clr;
    logic [4:0] clr;
    @(negedge clk);
    exp_ir = !pend[issue_id] && (reserved_count() < int'(MAXO));
    exp_lr = fq.size() < int'(DEPTH);
    if (rst_n) begin
      chk("issue_ready", 32'(issue_ready), 32'(exp_ir));
      chk("lsu_ready", 32'(lsu_ready), 32'(exp_lr));
      chk("rs_pending", 32'(rs_pending), 32'(pend[rs_id] && rs_id != 0));
      chk("rt_pending", 32'(rt_pending), 32'(pend[rt_id] && rt_id != 0));
`ifdef WB_BYPASS_EN
      chk("rs_fwd", 32'(rs_fwd), 32'(m_we && m_id == rs_id && rs_id != 0));
      chk("rt_fwd", 32'(rt_fwd), 32'(m_we && m_id == rt_id && rt_id != 0));
      if (rs_fwd) chk("rs_fwd_data", rs_fwd_data, m_d);
`endif
    end
    if (!rst_n) begin
      fq.delete();
      for (int i = 0; i < 32; i++) pend[i] = 1'b0;
      m_we = 1'b0; m_from_lsu = 1'b0; m_id = '0; m_d = '0;
    end else begin
      have_clr = 1'b0;
      clr      = '0;
      if (!BYP && m_we && m_from_lsu) begin
        have_clr = 1'b1;
        clr      = m_id;
      end
      if (alu_valid && alu_id != 0) begin
        m_we = 1'b1; m_id = alu_id; m_d = alu_data; m_from_lsu = 1'b0;
      end else if (fq.size() > 0) begin
        pe = fq.pop_front();
        m_we = 1'b1; m_id = pe.id; m_d = pe.d; m_from_lsu = 1'b1;
        if (BYP) begin
          have_clr = 1'b1;
          clr      = pe.id;
        end
      end else begin
        m_we = 1'b0; m_id = '0; m_d = '0; m_from_lsu = 1'b0;
      end
      if (lsu_valid && exp_lr && lsu_id != 0) fq.push_back('{lsu_id, lsu_data});
      if (have_clr) pend[clr] = 1'b0;
      if (issue_valid && exp_ir && issue_id != 0) pend[issue_id] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("enable_write", 32'(enable_write), 32'(m_we));
    if (m_we) begin
      chk("write_id", 32'(write_id), 32'(m_id));
      chk("write_data", write_data, m_d);
    end
  endtask

  initial begin
    logic [4:0] pl[$];
    logic [4:0] cand;
    rst_n = 1'b0;
    idle();
    alu_id = '0; alu_data = '0; issue_id = '0; lsu_id = '0; lsu_data = '0;
    rs_id = '0; rt_id = '0;

    // Reset state
    step(); step();
    chk("rst_we", 32'(enable_write), 32'd0);
    chk("rst_wid", 32'(write_id), 32'd0);
    chk("rst_wdata", write_data, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_lsu_ready", 32'(lsu_ready), 32'd1);
    chk("rel_issue_ready", 32'(issue_ready), 32'd1);

    // ALU result: one-cycle latency
    alu_valid = 1'b1; alu_id = 5'd5; alu_data = 32'h1234;
    step(); idle();
    chk("alu_we", 32'(enable_write), 32'd1);
    chk("alu_wid", 32'(write_id), 32'd5);
    chk("alu_wdata", write_data, 32'h1234);

    // Reserve r8, complete it through the LSU
    issue_valid = 1'b1; issue_id = 5'd8;
    step(); idle();
    rs_id = 5'd8;
    #1 chk("pend8_set", 32'(rs_pending), 32'd1);
    lsu_valid = 1'b1; lsu_id = 5'd8; lsu_data = 32'hDEAD;
    step(); idle();
    chk("lsu_not_next_edge", 32'(enable_write), 32'd0);
    step();
    chk("lsu_we", 32'(enable_write), 32'd1);
    chk("lsu_wid", 32'(write_id), 32'd8);
    chk("lsu_wdata", write_data, 32'hDEAD);
    chk("pend8_during_write", 32'(rs_pending), 32'(!BYP));
    step();
    chk("pend8_cleared", 32'(rs_pending), 32'd0);

    // ALU busy three cycles while two LSU results queue up
    alu_valid = 1'b1; alu_id = 5'd10; alu_data = 32'hA;
    lsu_valid = 1'b1; lsu_id = 5'd11; lsu_data = 32'hB;
    step();
    alu_id = 5'd12; alu_data = 32'hC;
    lsu_id = 5'd13; lsu_data = 32'hD;
    step();
    alu_id = 5'd14; alu_data = 32'hE;
    lsu_id = 5'd15; lsu_data = 32'hF;
    #1 chk("fifo_full_ready", 32'(lsu_ready), 32'd0);
    step(); idle();
    chk("alu_third_wid", 32'(write_id), 32'd14);
    step();
    chk("fifo_first_wid", 32'(write_id), 32'd11);
    step();
    chk("fifo_second_wid", 32'(write_id), 32'd13);
    step();
    chk("fifo_drained", 32'(enable_write), 32'd0);

    // Outstanding limit and re-issue of a pending id
    for (int i = 1; i <= 4; i++) begin
      issue_valid = 1'b1; issue_id = 5'(i);
      step();
    end
    issue_id = 5'd5;
    #1 chk("limit_issue5", 32'(issue_ready), 32'd0);
    issue_id = 5'd3;
    #1 chk("reissue3", 32'(issue_ready), 32'd0);
    step(); idle();
    for (int i = 1; i <= 4; i++) begin
      lsu_valid = 1'b1; lsu_id = 5'(i); lsu_data = $urandom;
      step();
    end
    idle();
    repeat (4) step();

    // r0 results and reservations are ignored
    alu_valid = 1'b1; alu_id = 5'd0; alu_data = 32'hFFFF;
    step(); idle();
    chk("alu_r0_no_write", 32'(enable_write), 32'd0);
    lsu_valid = 1'b1; lsu_id = 5'd0; lsu_data = 32'hEEEE;
    step(); idle();
    step();
    chk("lsu_r0_no_write", 32'(enable_write), 32'd0);
    issue_valid = 1'b1; issue_id = 5'd0;
    step(); idle();
    rs_id = 5'd0;
    #1 chk("issue_r0_no_pending", 32'(rs_pending), 32'd0);
    step();

    // Reset with full buffer and three reservations
    for (int i = 20; i <= 22; i++) begin
      issue_valid = 1'b1; issue_id = 5'(i);
      step();
    end
    idle();
    alu_valid = 1'b1; alu_id = 5'd23; alu_data = 32'h23;
    lsu_valid = 1'b1; lsu_id = 5'd20; lsu_data = 32'h20;
    step();
    alu_id = 5'd24; alu_data = 32'h24;
    lsu_id = 5'd21; lsu_data = 32'h21;
    step(); idle();
    #1 chk("pre_rst_full", 32'(lsu_ready), 32'd0);
    rst_n = 1'b0;
    step();
    chk("mid_rst_we", 32'(enable_write), 32'd0);
    chk("mid_rst_wid", 32'(write_id), 32'd0);
    chk("mid_rst_wdata", write_data, 32'd0);
    rst_n = 1'b1;
    issue_id = 5'd20; rs_id = 5'd20;
    #1;
    chk("post_rst_lsu_ready", 32'(lsu_ready), 32'd1);
    chk("post_rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("post_rst_pending", 32'(rs_pending), 32'd0);
    repeat (3) begin
      step();
      chk("post_rst_no_write", 32'(enable_write), 32'd0);
    end

    // Randomized traffic against the model
    repeat (600) begin
      rst_n = ($urandom_range(0, 199) != 0);
      pl.delete();
      for (int i = 1; i < 32; i++) if (pend[i]) pl.push_back(5'(i));
      alu_valid = ($urandom_range(0, 1) == 1);
      alu_data  = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        alu_id = 5'd0;
      end else begin
        alu_id = 5'd0;
        for (int t = 0; t < 8; t++) begin
          cand = 5'($urandom_range(1, 31));
          if (!pend[cand] && alu_id == 0) alu_id = cand;
        end
        if (alu_id == 0) alu_valid = 1'b0;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_id    = 5'($urandom_range(0, 31));
      lsu_valid   = ($urandom_range(0, 4) < 2);
      lsu_data    = $urandom;
      if (pl.size() > 0 && $urandom_range(0, 9) < 7)
        lsu_id = pl[$urandom_range(0, 32'(pl.size() - 1))];
      else
        lsu_id = 5'($urandom_range(0, 31));
      rs_id = 5'($urandom_range(0, 31));
      if (pl.size() > 0 && $urandom_range(0, 1) == 1)
        rt_id = pl[$urandom_range(0, 32'(pl.size() - 1))];
      else
        rt_id = 5'($urandom_range(0, 31));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
